// File: rtl/audio_pdm_adc.sv
// Stereo PDM microphone receiver: generates the PDM bit clock, samples L/R on opposite
// phases, decimates each stream with a 3rd-order CIC and emits {right,left} PCM on AXI-stream.
module audio_pdm_adc #(
  parameter int unsigned PDM_CLK_DIV = 16,
  parameter int unsigned DECIMATION  = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        pdm_data_i,
  output logic        pdm_clk_o,
  output logic        outport_tvalid_o,
  output logic [31:0] outport_tdata_o,
  output logic [3:0]  outport_tstrb_o,
  output logic [3:0]  outport_tdest_o,
  output logic        outport_tlast_o,
  input  logic        outport_tready_i,
  output logic        overrun_o
);

  localparam int unsigned HALF     = PDM_CLK_DIV / 2;
  localparam int unsigned DIV_W    = $clog2(PDM_CLK_DIV);
  localparam int unsigned DEC_W    = $clog2(DECIMATION);
  localparam int unsigned CIC_W    = 2 + 3 * DEC_W;
  localparam int unsigned SHIFT    = 3 * DEC_W - 15;
  localparam int unsigned CH_LEFT  = 0;
  localparam int unsigned CH_RIGHT = 1;

  logic [1:0]       sync_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             pdm_clk_q;
  logic [DEC_W-1:0] dec_q;
  logic             frame_p1_q;
  logic             frame_p2_q;
  logic             stb_c [2];
  logic             frame_c;
  logic signed [CIC_W-1:0] x_c;
  logic signed [CIC_W-1:0] integ_q [2][3];
  logic signed [CIC_W-1:0] dly_q   [2][3];
  logic signed [CIC_W-1:0] comb_c  [2][3];
  logic signed [CIC_W-1:0] comb_q  [2];
  logic signed [CIC_W-1:0] sh_c    [2];
  logic [15:0]      pcm_c [2];
  logic             tvalid_q;
  logic [31:0]      tdata_q;
  logic             overrun_q;
  logic             xfer_c;

  // Two-flop synchroniser for the shared mic data line
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sync_q <= '0;
    else        sync_q <= {sync_q[0], pdm_data_i};
  end

  always_comb begin
    div_d = '0;
    if (enable_i && (div_q != DIV_W'(PDM_CLK_DIV - 1))) div_d = div_q + DIV_W'(1);
  end

  // pdm_clk_q is computed from div_d so it tracks div_q exactly
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      div_q     <= '0;
      pdm_clk_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      pdm_clk_q <= (div_d >= DIV_W'(HALF));
    end
  end

  always_comb begin
    stb_c[CH_RIGHT] = enable_i && (div_q == DIV_W'(HALF - 1));
    stb_c[CH_LEFT]  = enable_i && (div_q == DIV_W'(PDM_CLK_DIV - 1));
    frame_c         = stb_c[CH_RIGHT] && (dec_q == '1);
    x_c             = sync_q[1] ? CIC_W'(1) : '1;
  end

  // Integrators and decimation counter; wrap-around is intentional
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dec_q      <= '0;
      frame_p1_q <= 1'b0;
      frame_p2_q <= 1'b0;
      for (int ch = 0; ch < 2; ch++)
        for (int s = 0; s < 3; s++) integ_q[ch][s] <= '0;
    end else if (!enable_i) begin
      dec_q      <= '0;
      frame_p1_q <= 1'b0;
      frame_p2_q <= 1'b0;
      for (int ch = 0; ch < 2; ch++)
        for (int s = 0; s < 3; s++) integ_q[ch][s] <= '0;
    end else begin
      if (stb_c[CH_RIGHT]) dec_q <= dec_q + DEC_W'(1);
      frame_p1_q <= frame_c;
      frame_p2_q <= frame_p1_q;
      for (int ch = 0; ch < 2; ch++) begin
        if (stb_c[ch]) begin
          integ_q[ch][0] <= integ_q[ch][0] + x_c;
          integ_q[ch][1] <= integ_q[ch][1] + integ_q[ch][0];
          integ_q[ch][2] <= integ_q[ch][2] + integ_q[ch][1];
        end
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      comb_c[ch][0] = integ_q[ch][2] - dly_q[ch][0];
      comb_c[ch][1] = comb_c[ch][0]  - dly_q[ch][1];
      comb_c[ch][2] = comb_c[ch][1]  - dly_q[ch][2];
    end
  end

  // Comb stages evaluated once per frame, one cycle after the frame-end strobe
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int ch = 0; ch < 2; ch++) begin
        comb_q[ch] <= '0;
        for (int s = 0; s < 3; s++) dly_q[ch][s] <= '0;
      end
    end else if (!enable_i) begin
      for (int ch = 0; ch < 2; ch++) begin
        comb_q[ch] <= '0;
        for (int s = 0; s < 3; s++) dly_q[ch][s] <= '0;
      end
    end else if (frame_p1_q) begin
      for (int ch = 0; ch < 2; ch++) begin
        comb_q[ch]   <= comb_c[ch][2];
        dly_q[ch][0] <= integ_q[ch][2];
        dly_q[ch][1] <= comb_c[ch][0];
        dly_q[ch][2] <= comb_c[ch][1];
      end
    end
  end

  // Scale to 16 bits; saturate when the bits above bit 15 are not pure sign extension
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      sh_c[ch]  = comb_q[ch] >>> SHIFT;
      pcm_c[ch] = sh_c[ch][15:0];
      if ((sh_c[ch][CIC_W-1:15] != '0) && (sh_c[ch][CIC_W-1:15] != '1))
        pcm_c[ch] = sh_c[ch][CIC_W-1] ? 16'h8000 : 16'h7FFF;
    end
  end

  assign xfer_c = tvalid_q && outport_tready_i;

  // Output holding register; a frame arriving while one is still pending is dropped
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (frame_p2_q && (!tvalid_q || xfer_c)) begin
        tvalid_q <= 1'b1;
        tdata_q  <= {pcm_c[CH_RIGHT], pcm_c[CH_LEFT]};
      end else if (frame_p2_q) begin
        overrun_q <= 1'b1;
      end else if (xfer_c) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign pdm_clk_o        = pdm_clk_q;
  assign outport_tvalid_o = tvalid_q;
  assign outport_tdata_o  = tdata_q;
  assign outport_tstrb_o  = 4'hF;
  assign outport_tdest_o  = 4'h0;
  assign outport_tlast_o  = 1'b1;
  assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_audio_pdm_adc.sv
// Directed bench for audio_pdm_adc: DC inputs, L/R split, backpressure, reset and enable.
module tb_audio_pdm_adc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        pdm_data_i;
  logic        pdm_clk_o;
  logic        outport_tvalid_o;
  logic [31:0] outport_tdata_o;
  logic [3:0]  outport_tstrb_o;
  logic [3:0]  outport_tdest_o;
  logic        outport_tlast_o;
  logic        outport_tready_i;
  logic        overrun_o;
  logic [1:0]  mode;

  int errors = 0;
  int checks = 0;

  // Frame-end strobe is the 64th right strobe (first at div_q=7), plus two pipeline stages
  localparam int FIRST_LAT = 8 + 63 * 16 + 2;
  localparam int PERIOD_M1 = 1023;

  audio_pdm_adc dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .enable_i         (enable_i),
    .pdm_data_i       (pdm_data_i),
    .pdm_clk_o        (pdm_clk_o),
    .outport_tvalid_o (outport_tvalid_o),
    .outport_tdata_o  (outport_tdata_o),
    .outport_tstrb_o  (outport_tstrb_o),
    .outport_tdest_o  (outport_tdest_o),
    .outport_tlast_o  (outport_tlast_o),
    .outport_tready_i (outport_tready_i),
    .overrun_o        (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // mode 0/1: constant data; mode 2: data follows pdm_clk_o (left hears 1, right hears 0)
  assign pdm_data_i = (mode == 2'd2) ? pdm_clk_o : mode[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!outport_tvalid_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    if (!outport_tvalid_o) check("valid_timeout", 32'(outport_tvalid_o), 32'd1);
  endtask

  initial begin
    int n;
    int ovr;
    int bad;
    int xfers;
    int k;
    logic [31:0] held;

    rst_i = 1'b0;
    enable_i = 1'b0;
    outport_tready_i = 1'b1;
    mode = 2'd1;
    #3;
    check("rst_pdm_clk", 32'(pdm_clk_o), 32'd0);
    check("rst_tvalid", 32'(outport_tvalid_o), 32'd0);
    check("rst_tdata", outport_tdata_o, 32'h0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("const_fields", {23'd0, outport_tstrb_o, outport_tdest_o, outport_tlast_o}, {23'd0, 4'hF, 4'h0, 1'b1});
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    enable_i = 1'b1;

    // Full-scale +1: clamps to 0x7FFF on both channels, one-cycle pulse every 1024 cycles
    wait_valid(2000, n);
    check("first_latency", 32'(n), 32'(FIRST_LAT));
    for (int f = 2; f <= 5; f++) begin
      @(negedge clk_i);
      check("pulse_width", 32'(outport_tvalid_o), 32'd0);
      wait_valid(1100, n);
      check("period", 32'(n), 32'(PERIOD_M1));
      if (f >= 4) check("ones_data", outport_tdata_o, 32'h7FFF7FFF);
    end
    @(negedge clk_i);

    // Full-scale -1: exactly -32768, no clamp needed
    mode = 2'd0;
    for (int f = 1; f <= 5; f++) begin
      wait_valid(1100, n);
      if (f >= 4) check("zeros_data", outport_tdata_o, 32'h80008000);
      @(negedge clk_i);
    end

    // Left sees 1, right sees 0
    mode = 2'd2;
    for (int f = 1; f <= 5; f++) begin
      wait_valid(1100, n);
      if (f >= 4) check("split_data", outport_tdata_o, 32'h80007FFF);
      @(negedge clk_i);
    end

    // Backpressure across three frame periods
    outport_tready_i = 1'b0;
    wait_valid(1100, n);
    held = outport_tdata_o;
    check("hold_first", held, 32'h80007FFF);
    ovr = 0;
    bad = 0;
    repeat (2348) begin
      @(negedge clk_i);
      if (overrun_o) ovr++;
      if (!outport_tvalid_o || outport_tdata_o !== held) bad++;
    end
    check("overrun_pulses", 32'(ovr), 32'd2);
    check("hold_stable", 32'(bad), 32'd0);
    outport_tready_i = 1'b1;
    xfers = 0;
    repeat (5) begin
      if (outport_tvalid_o && outport_tready_i) xfers++;
      @(negedge clk_i);
    end
    check("release_xfers", 32'(xfers), 32'd1);
    check("release_idle", 32'(outport_tvalid_o), 32'd0);

    // Asynchronous reset mid-frame with a frame pending and pdm_clk_o high
    outport_tready_i = 1'b0;
    wait_valid(1100, n);
    repeat (480) @(negedge clk_i);
    k = 0;
    while (!pdm_clk_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    check("pre_rst_clk", 32'(pdm_clk_o), 32'd1);
    check("pre_rst_valid", 32'(outport_tvalid_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check("mid_rst_clk", 32'(pdm_clk_o), 32'd0);
    check("mid_rst_valid", 32'(outport_tvalid_o), 32'd0);
    check("mid_rst_data", outport_tdata_o, 32'h0);
    repeat (3) @(negedge clk_i);
    outport_tready_i = 1'b1;
    mode = 2'd1;
    rst_i = 1'b1;
    wait_valid(2000, n);
    check("post_rst_latency", 32'(n), 32'(FIRST_LAT));
    @(negedge clk_i);

    // Disable for 500 cycles with a frame pending
    outport_tready_i = 1'b0;
    wait_valid(1100, n);
    repeat (300) @(negedge clk_i);
    enable_i = 1'b0;
    bad = 0;
    ovr = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_i);
      if (pdm_clk_o) bad++;
      if (overrun_o) ovr++;
      if (i == 100) begin
        check("pending_kept", 32'(outport_tvalid_o), 32'd1);
        outport_tready_i = 1'b1;
      end
      if (i == 101) check("xfer_while_off", 32'(outport_tvalid_o), 32'd0);
    end
    check("off_clk_low", 32'(bad), 32'd0);
    check("off_no_overrun", 32'(ovr), 32'd0);
    enable_i = 1'b1;
    wait_valid(2000, n);
    check("reenable_latency", 32'(n), 32'(FIRST_LAT));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
